// File: rtl/cmul_stream_arbiter.sv
// rtl/cmul_stream_arbiter.sv - round-robin packet arbiter sharing one cmul datapath among NUM_REQ streams
// Grant order is kept in a tag FIFO so in-order datapath results route back to their requester.
module cmul_stream_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 16,
   parameter int SCALING_WIDTH = 18,
   parameter int TAG_DEPTH     = 8
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic [NUM_REQ-1:0]                  s_tvalid,
   input  logic [NUM_REQ-1:0]                  s_tlast,
   output logic [NUM_REQ-1:0]                  s_tready,
   input  logic [NUM_REQ*2*DATA_WIDTH-1:0]     s_adata,
   input  logic [NUM_REQ*2*DATA_WIDTH-1:0]     s_bdata,
   input  logic [NUM_REQ*SCALING_WIDTH-1:0]    s_scale,
   output logic                                m_tvalid,
   output logic                                m_tlast,
   input  logic                                m_tready,
   output logic [2*DATA_WIDTH-1:0]             m_adata,
   output logic [2*DATA_WIDTH-1:0]             m_bdata,
   output logic [SCALING_WIDTH-1:0]            m_scale,
   input  logic                                r_tvalid,
   input  logic                                r_tlast,
   output logic                                r_tready,
   input  logic [2*DATA_WIDTH-1:0]             r_pdata,
   output logic [NUM_REQ-1:0]                  o_tvalid,
   output logic [NUM_REQ-1:0]                  o_tlast,
   input  logic [NUM_REQ-1:0]                  o_tready,
   output logic [NUM_REQ*2*DATA_WIDTH-1:0]     o_pdata,
   output logic [$clog2(NUM_REQ)-1:0]          grant_id,
   output logic                                busy,
   output logic                                err_orphan
);
   localparam int CW    = 2*DATA_WIDTH;
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(TAG_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {IDLE, PKT} state_t;
   state_t state, state_nx;

   logic [ID_W-1:0]          rr;
   logic [ID_W-1:0]          tag_mem [TAG_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [CNT_W-1:0]         count;
   logic                     fifo_full, fifo_empty;
   logic                     push, pop, pkt_end, orphan;
   logic                     win_found;
   logic [ID_W-1:0]          winner, cand, head;
   logic                     sel_valid, sel_last;
   logic [CW-1:0]            sel_adata, sel_bdata;
   logic [SCALING_WIDTH-1:0] win_scale;

   assign fifo_full  = (count == CNT_W'(TAG_DEPTH));
   assign fifo_empty = (count == '0);
   assign head       = tag_mem[rd_ptr];
   assign o_pdata    = {NUM_REQ{r_pdata}};

   // Search starts just after the last winner, so the last winner has lowest priority.
   always_comb begin
      winner    = '0;
      win_found = 1'b0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = ID_W'((int'(rr) + i) % NUM_REQ);
         if (!win_found && s_tvalid[cand]) begin
            winner    = cand;
            win_found = 1'b1;
         end
      end
   end

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_adata = '0;
      sel_bdata = '0;
      win_scale = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_id == ID_W'(k)) begin
            sel_valid = s_tvalid[k];
            sel_last  = s_tlast[k];
            sel_adata = s_adata[k*CW +: CW];
            sel_bdata = s_bdata[k*CW +: CW];
         end
         if (winner == ID_W'(k))
            win_scale = s_scale[k*SCALING_WIDTH +: SCALING_WIDTH];
      end
   end

   always_comb begin
      state_nx = state;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      m_adata  = '0;
      m_bdata  = '0;
      s_tready = '0;
      push     = 1'b0;
      pkt_end  = 1'b0;
      case (state)
         IDLE: begin
            if (win_found && !fifo_full) begin
               push     = 1'b1;
               state_nx = PKT;
            end
         end
         PKT: begin
            m_tvalid           = sel_valid;
            m_tlast            = sel_last;
            m_adata            = sel_adata;
            m_bdata            = sel_bdata;
            s_tready[grant_id] = m_tready;
            if (sel_valid && m_tready && sel_last) begin
               pkt_end  = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Results with no outstanding tag are refused rather than guessed at.
   always_comb begin
      o_tvalid = '0;
      o_tlast  = '0;
      r_tready = 1'b0;
      pop      = 1'b0;
      orphan   = 1'b0;
      if (!fifo_empty) begin
         o_tvalid[head] = r_tvalid;
         o_tlast[head]  = r_tlast;
         r_tready       = o_tready[head];
         pop            = r_tvalid && o_tready[head] && r_tlast;
      end else begin
         orphan = r_tvalid;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         rr         <= ID_W'(NUM_REQ-1);
         grant_id   <= '0;
         m_scale    <= '0;
         busy       <= 1'b0;
         err_orphan <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
      end else begin
         state <= state_nx;
         if (push) begin
            grant_id <= winner;
            rr       <= winner;
            m_scale  <= win_scale;
            busy     <= 1'b1;
            wr_ptr   <= wr_ptr + 1'b1;
         end else if (pkt_end) begin
            busy <= 1'b0;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (orphan)
            err_orphan <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         tag_mem[wr_ptr] <= winner;
   end
endmodule

// File: tb/tb_cmul_stream_arbiter.sv
// tb/tb_cmul_stream_arbiter.sv - scoreboard bench for cmul_stream_arbiter with a behavioural datapath
// Sources, datapath and sinks are modelled per cycle; results are matched in acceptance order.
module tb_cmul_stream_arbiter;
   localparam int N  = 4;
   localparam int DW = 16;
   localparam int SW = 18;
   localparam int TD = 2;
   localparam int CW = 2*DW;
   localparam int IW = $clog2(N);

   logic              clk = 1'b0;
   logic              reset_n;
   logic [N-1:0]      s_tvalid, s_tlast, s_tready;
   logic [N*CW-1:0]   s_adata, s_bdata;
   logic [N*SW-1:0]   s_scale;
   logic              m_tvalid, m_tlast, m_tready;
   logic [CW-1:0]     m_adata, m_bdata;
   logic [SW-1:0]     m_scale;
   logic              r_tvalid, r_tlast, r_tready;
   logic [CW-1:0]     r_pdata;
   logic [N-1:0]      o_tvalid, o_tlast, o_tready;
   logic [N*CW-1:0]   o_pdata;
   logic [IW-1:0]     grant_id;
   logic              busy, err_orphan;

   always #5 clk = ~clk;

   cmul_stream_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .SCALING_WIDTH(SW), .TAG_DEPTH(TD)) dut (
      .clk(clk), .reset_n(reset_n),
      .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .s_adata(s_adata), .s_bdata(s_bdata), .s_scale(s_scale),
      .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .m_adata(m_adata), .m_bdata(m_bdata), .m_scale(m_scale),
      .r_tvalid(r_tvalid), .r_tlast(r_tlast), .r_tready(r_tready), .r_pdata(r_pdata),
      .o_tvalid(o_tvalid), .o_tlast(o_tlast), .o_tready(o_tready), .o_pdata(o_pdata),
      .grant_id(grant_id), .busy(busy), .err_orphan(err_orphan)
   );

   typedef struct packed {logic [IW-1:0] req; logic [CW-1:0] data; logic last;} exp_t;
   typedef struct packed {logic [CW-1:0] data; logic last;} dp_t;
   typedef struct {int req; int len; logic [SW-1:0] scale; int exp_grant; logic [SW-1:0] exp_scale;} vec_t;

   exp_t          exp_q[$];
   dp_t           dp_q[$];
   int            grant_log[$];
   int            gap_log[$];
   int            left[N], seq[N], reload_len[N], reload_cnt[N];
   logic [SW-1:0] scale_v[N];
   logic [N-1:0]  ovr_en;
   logic [N-1:0]  o_rdy;
   logic          m_rdy, drive_orphan, prev_busy;
   int            gap_cnt;
   int            n_tests = 0;
   int            n_fail  = 0;
   vec_t          vecs[5];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] cur_a(int k);
      if (ovr_en[k]) return 32'h4000_0000;
      return {8'(k+1), 8'(seq[k]), 16'(seq[k]*37 + k)};
   endfunction

   function automatic logic [CW-1:0] cur_b(int k);
      if (ovr_en[k]) return 32'h4000_0000;
      return {16'(seq[k]*5 + 3), 8'(k), 8'(seq[k] ^ k)};
   endfunction

   // Stand-in for the shared multiplier: any fixed function works for routing checks.
   function automatic logic [CW-1:0] dp_func(logic [CW-1:0] a, logic [CW-1:0] b);
      return a + b;
   endfunction

   task automatic clear_models();
      for (int k = 0; k < N; k++) begin
         left[k] = 0; seq[k] = 0; reload_len[k] = 0; reload_cnt[k] = 0; scale_v[k] = '0;
      end
      exp_q.delete(); dp_q.delete(); grant_log.delete(); gap_log.delete();
      gap_cnt = 0; prev_busy = 1'b0; drive_orphan = 1'b0; ovr_en = '0;
      s_tvalid = '0; s_tlast = '0; r_tvalid = 1'b0; r_tlast = 1'b0; r_pdata = '0;
   endtask

   task automatic cycle();
      exp_t e;
      @(negedge clk);
      m_tready = m_rdy;
      o_tready = o_rdy;
      for (int k = 0; k < N; k++) begin
         s_tvalid[k]            = (left[k] > 0);
         s_tlast[k]             = (left[k] == 1);
         s_adata[k*CW +: CW]    = cur_a(k);
         s_bdata[k*CW +: CW]    = cur_b(k);
         s_scale[k*SW +: SW]    = scale_v[k];
      end
      r_tvalid = drive_orphan || (dp_q.size() > 0);
      r_pdata  = (dp_q.size() > 0) ? dp_q[0].data : '0;
      r_tlast  = (dp_q.size() > 0) ? dp_q[0].last : 1'b0;
      #1;
      if (r_tvalid && r_tready && dp_q.size() > 0) void'(dp_q.pop_front());
      if (m_tvalid && m_tready) dp_q.push_back({dp_func(m_adata, m_bdata), m_tlast});
      for (int k = 0; k < N; k++) begin
         if (s_tvalid[k] && s_tready[k]) begin
            exp_q.push_back({IW'(k), dp_func(cur_a(k), cur_b(k)), s_tlast[k]});
            left[k]--; seq[k]++;
            if (left[k] == 0 && reload_cnt[k] > 0) begin
               left[k] = reload_len[k];
               reload_cnt[k]--;
            end
         end
      end
      if (o_tvalid != '0) check("o_onehot", $countones(o_tvalid), 1);
      for (int k = 0; k < N; k++) begin
         if (o_tvalid[k] && o_tready[k]) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("sb_result", {IW'(k), o_pdata[k*CW +: CW], o_tlast[k]}, e);
            end
         end
      end
      if (busy && !prev_busy) begin
         grant_log.push_back(int'(grant_id));
         gap_log.push_back(gap_cnt);
         gap_cnt = 0;
      end
      if (!busy) gap_cnt++;
      prev_busy = busy;
   endtask

   task automatic wait_grant();
      int n0 = grant_log.size();
      int t  = 0;
      while (grant_log.size() == n0 && t < 40) begin
         cycle();
         t++;
      end
      if (grant_log.size() == n0) check("grant_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      int  t = 0;
      bit  done = 0;
      while (!done && t < 300) begin
         cycle();
         t++;
         done = !busy && exp_q.size() == 0 && dp_q.size() == 0;
         for (int k = 0; k < N; k++) if (left[k] != 0) done = 0;
      end
      check("drain", done, 1);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      reset_n = 1'b0;
      clear_models();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{0, 3, 18'h10000, 0, 18'h10000};
      vecs[1] = '{2, 1, 18'h08000, 2, 18'h08000};
      vecs[2] = '{1, 2, 18'h3FFFF, 1, 18'h3FFFF};
      vecs[3] = '{3, 4, 18'h00001, 3, 18'h00001};
      vecs[4] = '{0, 1, 18'h20000, 0, 18'h20000};

      reset_n = 1'b0;
      clear_models();
      m_rdy = 1'b0; o_rdy = '0; m_tready = 1'b0; o_tready = '0;
      s_adata = '0; s_bdata = '0; s_scale = '0;
      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_grant", grant_id, 0);
      check("rst_err", err_orphan, 0);
      check("rst_scale", m_scale, 0);
      check("rst_s_tready", s_tready, 0);
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_o_tvalid", o_tvalid, 0);
      check("rst_r_tready", r_tready, 0);
      @(negedge clk);
      reset_n = 1'b1;
      m_rdy = 1'b1; o_rdy = '1;

      for (int i = 0; i < 5; i++) begin
         scale_v[vecs[i].req] = vecs[i].scale;
         left[vecs[i].req]    = vecs[i].len;
         wait_grant();
         check("tbl_grant", grant_id, vecs[i].exp_grant);
         check("tbl_scale", m_scale, vecs[i].exp_scale);
         wait_drain();
      end

      reset_pulse();
      for (int k = 0; k < N; k++) begin
         left[k] = 3; reload_len[k] = 3;
      end
      reload_cnt[0] = 1;
      wait_drain();
      check("rr_count", grant_log.size(), 5);
      if (grant_log.size() == 5) begin
         check("rr_g0", grant_log[0], 0);
         check("rr_g1", grant_log[1], 1);
         check("rr_g2", grant_log[2], 2);
         check("rr_g3", grant_log[3], 3);
         check("rr_g4", grant_log[4], 0);
         for (int i = 1; i < 5; i++) check("rr_gap", gap_log[i], 1);
      end

      scale_v[2] = 18'h10000;
      left[2] = 4;
      wait_grant();
      scale_v[2] = 18'h08000;
      for (int t = 0; t < 10; t++) begin
         if (!busy) break;
         if (m_tvalid && m_tready) check("hold_scale", m_scale, 18'h10000);
         cycle();
      end
      wait_drain();
      left[2] = 2;
      wait_grant();
      check("next_scale", m_scale, 18'h08000);
      wait_drain();

      ovr_en[1] = 1'b1;
      scale_v[1] = 18'h10000;
      o_rdy = '0;
      left[1] = 2;
      wait_grant();
      check("rt_grant1", grant_id, 1);
      left[3] = 2;
      wait_grant();
      check("rt_grant3", grant_id, 3);
      repeat (4) cycle();
      check("rt_hold_valid", o_tvalid, 4'b0010);
      check("rt_hold_ready", r_tready, 0);
      o_rdy = '1;
      wait_drain();

      reset_pulse();
      o_rdy = '0;
      left[0] = 1; left[1] = 1; left[2] = 1;
      repeat (8) cycle();
      check("full_grants", grant_log.size(), 2);
      check("full_busy", busy, 0);
      check("full_s_tready", s_tready, 0);
      check("full_m_tvalid", m_tvalid, 0);
      o_rdy = '1;
      cycle();
      check("full_pop_ready", r_tready, 1);
      cycle();
      check("full_wait_busy", busy, 0);
      cycle();
      check("full_third_busy", busy, 1);
      check("full_third_grant", grant_id, 2);
      wait_drain();

      drive_orphan = 1'b1;
      cycle();
      check("orph_r_tready", r_tready, 0);
      check("orph_o_tvalid", o_tvalid, 0);
      drive_orphan = 1'b0;
      cycle();
      check("orph_err_set", err_orphan, 1);
      repeat (3) cycle();
      check("orph_err_sticky", err_orphan, 1);
      reset_pulse();
      cycle();
      check("orph_err_clear", err_orphan, 0);

      left[2] = 4;
      wait_grant();
      cycle();
      #2;
      reset_n = 1'b0;
      #1;
      check("async_busy", busy, 0);
      check("async_m_tvalid", m_tvalid, 0);
      check("async_s_tready", s_tready, 0);
      clear_models();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      left[3] = 2; left[0] = 1;
      wait_grant();
      check("async_first_grant", grant_id, 0);
      wait_drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
